spi_slave_port: RTL and testbench
=================================

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for spi_sclk, spi_cs_n and spi_mosi (minimum 2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving RX FIFO entries (power of two); it is used only when SPI_SLAVE_FIFO_EN is defined.
REQ-003 clk  input  1  single system clock; all logic runs on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 spi_sclk  input  1  SPI clock from the external master; asynchronous to clk.
REQ-006 spi_cs_n  input  1  active-low chip select from the master.
REQ-007 spi_mosi  input  1  serial data from the master.
REQ-008 spi_miso  output  1  serial data to the master.
REQ-009 tx_byte  input  8  next byte to send to the master.
REQ-010 tx_valid  input  1  tx_byte is valid.
REQ-011 tx_ready  output  1  TX holding register is empty.
REQ-012 rx_byte  output  8  byte at the head of the RX buffer.
REQ-013 rx_valid  output  1  RX buffer is non-empty.
REQ-014 rx_read  input  1  pops the RX head.
REQ-015 rx_overrun  output  1  sticky flag: a received byte was dropped.
REQ-016 busy  output  1  synchronized chip select is active (low).

Function
REQ-017 The block SHALL be an SPI mode-0 responder (CPOL=0, CPHA=0), MSB first, 8-bit frames, with back-to-back bytes allowed under one chip select.
REQ-018 spi_sclk, spi_cs_n and spi_mosi SHALL pass through SYNC_STAGES flip-flops; SCLK edges are detected from the last two synchronized samples; clk SHALL be at least 8x the SCLK frequency.
REQ-019 The FSM SHALL have two states, IDLE and SHIFT: IDLE->SHIFT on the synchronized cs_n falling edge; SHIFT->IDLE on the synchronized cs_n rising edge.
REQ-020 On entry to SHIFT: the TX shift register loads the holding register (or 8'hFF if it is empty), the holding register is emptied, and the bit counter clears to 0.
REQ-021 On each synchronized SCLK rising edge in SHIFT: MOSI is shifted into the RX shift register LSB and the 3-bit counter increments, wrapping 7->0.
REQ-022 On each synchronized SCLK falling edge in SHIFT: the TX shift register shifts left, except after the 8th rising edge, when it reloads per REQ-020 instead.
REQ-023 spi_miso SHALL equal the TX shift register MSB while in SHIFT and 1'b1 in IDLE.
REQ-024 On the clk cycle that detects the 8th rising edge, the completed byte SHALL be pushed into the RX buffer, and rx_valid SHALL be high on the next cycle.
REQ-025 TX handshake: tx_valid && tx_ready loads tx_byte into the holding register on that cycle. tx_ready SHALL fall on the next cycle and rise again the cycle after the holding register is consumed.
REQ-026 RX buffer behaviour:
- rx_byte is the head entry, valid whenever rx_valid is high.
- rx_read while rx_valid pops one entry.
- rx_read while the buffer is empty is ignored.
REQ-027 A push into a full buffer SHALL drop the byte and set rx_overrun; a simultaneous push and pop while full SHALL succeed with no overrun.
REQ-028 rx_overrun SHALL clear on the cycle after any accepted rx_read.
REQ-029 On a cs_n rising edge mid-byte, the partial RX byte SHALL be discarded, nothing is pushed, and the counter clears.
REQ-030 busy SHALL equal the inverse of synchronized cs_n.

Reset
REQ-031 While rst is low, the following SHALL be forced:
- FSM to IDLE; counter 0; shift registers 8'h00.
- Holding register empty; RX buffer empty; pointers 0.
- Synchronizers high for sclk and cs_n, low for mosi.
- Outputs: spi_miso=1, tx_ready=1, rx_valid=0, rx_byte=8'h00, rx_overrun=0, busy=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer; after release, the block waits in IDLE for a fresh cs_n falling edge.

Configuration
REQ-033 With SPI_SLAVE_FIFO_EN defined, the RX buffer SHALL be a FIFO of FIFO_DEPTH entries with wrap-around pointers, and full means FIFO_DEPTH entries stored.
REQ-034 Without SPI_SLAVE_FIFO_EN, the RX buffer SHALL be a single-entry holding register (full = rx_valid), with identical handshake and overrun rules.

Verification
REQ-035 tx_byte=8'hA5 preloaded; master sends 8'h3C in one frame -> MISO shifts 10100101, and rx_byte=8'h3C with rx_valid high one cycle after the 8th edge.
REQ-036 No TX preload; master clocks two bytes under one CS -> MISO returns 8'hFF, 8'hFF, and two RX entries are queued in order.
REQ-037 FIFO enabled; 9 bytes sent with no rx_read -> first 8 retained, 9th dropped, rx_overrun=1; one rx_read -> rx_overrun=0, and the head becomes byte 2.
REQ-038 cs_n raised after 5 bits -> no push, rx_valid remains 0; the next full frame of 8'h81 is received correctly.
REQ-039 rst pulsed low mid-byte -> all outputs match their REQ-031 values within the reset cycle; the following frame of 8'h5A is received intact.
REQ-040 FIFO disabled; 2 bytes sent with no rx_read -> rx_byte holds the first, rx_overrun=1.

Source files
------------

// File: rtl/spi_slave_port_if.sv
// SPI responder bus bundle: serial pins toward the external master plus the
//   byte-wide TX/RX handshake toward local logic.
// The slave modport is the responder's view; master is the view of whatever drives the pins.
// Ports: spi_sclk/spi_cs_n/spi_mosi/spi_miso (serial), tx_byte/tx_valid/tx_ready (TX),
//   rx_byte/rx_valid/rx_read/rx_overrun (RX), busy (chip select active).
interface spi_slave_port_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_read;
  logic       rx_overrun;
  logic       busy;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_byte, tx_valid, rx_read,
    output spi_miso, tx_ready, rx_byte, rx_valid, rx_overrun, busy
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_byte, tx_valid, rx_read,
    input  spi_miso, tx_ready, rx_byte, rx_valid, rx_overrun, busy
  );
endinterface

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder (MSB first, 8-bit frames, back-to-back bytes under one CS).
// Latency: SYNC_STAGES+1 clk from an SCLK edge to its effect; rx_valid rises the cycle after the 8th-edge push.
// Backpressure: TX via tx_valid/tx_ready holding register (0xFF sent if empty); RX full drops the byte and sets rx_overrun.
// Ports: clk, rst (async active-low); bus (spi_slave_port_if.slave) carries the serial pins and byte handshakes.
// Build option: define SPI_SLAVE_FIFO_EN for a FIFO_DEPTH-entry RX FIFO; otherwise RX is a single holding register.
module spi_slave_port #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_slave_port_if.slave   bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Input synchronizers; sclk/cs_n idle high out of reset so no false edges appear.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_hold_vld_q, tx_hold_vld_d;
  logic       consume;
  logic       push;
  logic [7:0] push_dat;

  logic       pop;
  logic       rx_full;
  logic       rx_valid_w;
  logic       push_ok;
  logic       overrun_q;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    tx_hold_vld_d = tx_hold_vld_q;
    consume       = 1'b0;
    push          = 1'b0;
    push_dat      = {rx_shift_q[6:0], mosi_s};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = 3'd0;
          consume = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          // Partial byte is simply abandoned; rx_shift is overwritten by the next frame.
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (sclk_rise) begin
          rx_shift_d = push_dat;
          cnt_d      = cnt_q + 3'd1;
          push       = (cnt_q == 3'd7);
        end else if (sclk_fall) begin
          // Counter back at 0 on a falling edge means a byte just completed:
          // reload for the next back-to-back byte instead of shifting.
          if (cnt_q == 3'd0) begin
            consume = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      tx_shift_d    = tx_hold_vld_q ? tx_hold_q : 8'hFF;
      tx_hold_vld_d = 1'b0;
    end
    if (bus.tx_valid && !tx_hold_vld_q) begin
      tx_hold_d     = bus.tx_byte;
      tx_hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q   <= '1;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b1;
      cs_prev_q     <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'h00;
      tx_hold_q     <= 8'h00;
      tx_hold_vld_q <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      tx_hold_vld_q <= tx_hold_vld_d;
    end
  end

  assign bus.spi_miso = (state_q == SHIFT) ? tx_shift_q[7] : 1'b1;
  assign bus.tx_ready = ~tx_hold_vld_q;
  assign bus.busy     = ~cs_s;

  // RX buffer: a pop frees a slot in the same cycle, so push+pop while full is accepted.
  assign pop     = bus.rx_read & rx_valid_w;
  assign push_ok = push & (~rx_full | pop);

`ifdef SPI_SLAVE_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign rx_full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign rx_valid_w = (count_q != '0);
  assign bus.rx_byte = rx_valid_w ? mem_q[rd_ptr_q] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [7:0] rx_hold_q;
  logic       rx_hold_vld_q;

  assign rx_full     = rx_hold_vld_q;
  assign rx_valid_w  = rx_hold_vld_q;
  assign bus.rx_byte = rx_hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_hold_q     <= 8'h00;
      rx_hold_vld_q <= 1'b0;
    end else begin
      if (push_ok) begin
        rx_hold_q     <= push_dat;
        rx_hold_vld_q <= 1'b1;
      end else if (pop) begin
        rx_hold_vld_q <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else if (pop) begin
      overrun_q <= 1'b0;
    end else if (push && rx_full) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.rx_valid   = rx_valid_w;
  assign bus.rx_overrun = overrun_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Testbench for spi_slave_port: drives mode-0 SPI frames and the byte handshakes.
// Latency: SCLK half period is HALF clk cycles, well above the 8x minimum ratio.
// Backpressure: exercises TX preload/empty, RX overrun and mid-byte abort/reset.
module tb_spi_slave_port;
  localparam int HALF = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  spi_slave_port_if bus ();

  spi_slave_port #(.SYNC_STAGES(2), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mosi;
    logic       pre;
    logic [7:0] txb;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    bus.spi_cs_n = 1'b1;
    tick(HALF);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, output logic [7:0] m);
    m = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_mosi = d[i];
      tick(HALF);
      m[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      tick(HALF);
      bus.spi_sclk = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic pop();
    bus.rx_read = 1'b1;
    tick(1);
    bus.rx_read = 1'b0;
  endtask

  task automatic preload(input logic [7:0] b);
    bus.tx_byte  = b;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m, m2;
    logic       seen;
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{mosi: 8'h3C, pre: 1'b1, txb: 8'hA5, exp_miso: 8'hA5, exp_rx: 8'h3C};
    vecs[1] = '{mosi: 8'h81, pre: 1'b0, txb: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h81};
    vecs[2] = '{mosi: 8'h5A, pre: 1'b1, txb: 8'h00, exp_miso: 8'h00, exp_rx: 8'h5A};
    vecs[3] = '{mosi: 8'hFF, pre: 1'b1, txb: 8'h96, exp_miso: 8'h96, exp_rx: 8'hFF};
    vecs[4] = '{mosi: 8'h00, pre: 1'b1, txb: 8'h7E, exp_miso: 8'h7E, exp_rx: 8'h00};

    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_byte  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_read  = 1'b0;
    rst = 1'b0;
    tick(3);
    chk("reset_miso",     bus.spi_miso,   1);
    chk("reset_tx_ready", bus.tx_ready,   1);
    chk("reset_rx_valid", bus.rx_valid,   0);
    chk("reset_rx_byte",  bus.rx_byte,    0);
    chk("reset_overrun",  bus.rx_overrun, 0);
    chk("reset_busy",     bus.busy,       0);
    rst = 1'b1;
    tick(4);

    // Single-byte frames from the vector table.
    for (int v = 0; v < 5; v++) begin
      chk("tx_ready_before", bus.tx_ready, 1);
      if (vecs[v].pre) begin
        preload(vecs[v].txb);
        chk("tx_ready_after_load", bus.tx_ready, 0);
      end
      cs_low();
      chk("busy_in_frame", bus.busy, 1);
      chk("tx_ready_consumed", bus.tx_ready, 1);
      send_bits(vecs[v].mosi, 8, m);
      chk("frame_miso", m, vecs[v].exp_miso);
      chk("frame_rx_valid", bus.rx_valid, 1);
      chk("frame_rx_byte", bus.rx_byte, vecs[v].exp_rx);
      chk("frame_overrun", bus.rx_overrun, 0);
      cs_high();
      chk("busy_after_frame", bus.busy, 0);
      chk("miso_idle", bus.spi_miso, 1);
      pop();
      chk("rx_valid_after_pop", bus.rx_valid, 0);
    end

    // Two back-to-back bytes under one CS with no TX preload.
    cs_low();
    send_bits(8'h12, 8, m);
    send_bits(8'h34, 8, m2);
    cs_high();
    chk("b2b_miso0", m, 8'hFF);
    chk("b2b_miso1", m2, 8'hFF);
    chk("b2b_rx_valid", bus.rx_valid, 1);
    chk("b2b_head", bus.rx_byte, 8'h12);
`ifdef SPI_SLAVE_FIFO_EN
    chk("b2b_overrun", bus.rx_overrun, 0);
    pop();
    chk("b2b_second_valid", bus.rx_valid, 1);
    chk("b2b_second", bus.rx_byte, 8'h34);
    pop();
    chk("b2b_empty", bus.rx_valid, 0);

    // Nine bytes into an eight-entry FIFO with no reads.
    cs_low();
    for (int k = 1; k <= 9; k++) begin
      send_bits(8'(k), 8, m);
    end
    cs_high();
    chk("fifo_full_overrun", bus.rx_overrun, 1);
    chk("fifo_full_head", bus.rx_byte, 8'h01);
    pop();
    chk("fifo_overrun_clear", bus.rx_overrun, 0);
    chk("fifo_head_after_pop", bus.rx_byte, 8'h02);
    for (int k = 2; k <= 8; k++) begin
      chk("fifo_drain", bus.rx_byte, 32'(k));
      pop();
    end
    chk("fifo_drained", bus.rx_valid, 0);
`else
    chk("single_overrun", bus.rx_overrun, 1);
    pop();
    chk("single_overrun_clear", bus.rx_overrun, 0);
    chk("single_empty", bus.rx_valid, 0);
`endif
    // Read on an empty buffer is ignored.
    pop();
    chk("empty_read_valid", bus.rx_valid, 0);
    chk("empty_read_overrun", bus.rx_overrun, 0);

    // Abort after five bits, then a full 8'h81 frame with the 8th bit by hand.
    cs_low();
    send_bits(8'hF0, 5, m);
    cs_high();
    chk("abort_no_push", bus.rx_valid, 0);
    cs_low();
    send_bits(8'h81, 7, m);
    bus.spi_mosi = 1'b1;
    tick(HALF);
    m[0] = bus.spi_miso;
    chk("rx_valid_before_8th", bus.rx_valid, 0);
    bus.spi_sclk = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick(1);
      seen = bus.rx_valid;
    end
    chk("rx_valid_after_8th", seen, 1);
    tick(HALF);
    bus.spi_sclk = 1'b0;
    tick(HALF);
    cs_high();
    chk("abort_next_rx", bus.rx_byte, 8'h81);
    chk("abort_next_miso", m, 8'hFF);
    pop();

    // Reset pulsed mid-byte, then a clean 8'h5A frame.
    preload(8'h33);
    cs_low();
    send_bits(8'hC3, 4, m);
    chk("pre_reset_miso_bits", m[7:4], 4'h3);
    rst = 1'b0;
    #1;
    chk("mid_reset_miso",     bus.spi_miso,   1);
    chk("mid_reset_tx_ready", bus.tx_ready,   1);
    chk("mid_reset_rx_valid", bus.rx_valid,   0);
    chk("mid_reset_rx_byte",  bus.rx_byte,    0);
    chk("mid_reset_overrun",  bus.rx_overrun, 0);
    chk("mid_reset_busy",     bus.busy,       0);
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(4);
    chk("post_reset_idle", bus.busy, 0);
    cs_low();
    send_bits(8'h5A, 8, m);
    cs_high();
    chk("post_reset_rx_valid", bus.rx_valid, 1);
    chk("post_reset_rx_byte", bus.rx_byte, 8'h5A);
    chk("post_reset_miso", m, 8'hFF);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
